// File: rtl/vrf_read_port_arbiter.sv
// Two-port round-robin arbiter for vector register file reads.
// Up to two valid requesters are granted each cycle, starting at a rotating
// priority pointer; winners are steered onto free read ports and the port
// address/tag are registered for the VRF read-address inputs.
module vrf_read_port_arbiter #(
    parameter int NUM_REQ    = 8,
    parameter int PTR_WIDTH  = $clog2(NUM_REQ),
    parameter int ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [1:0]                    port_busy,
    input  logic                          flush,
    output logic                          rd0_en,
    output logic [ADDR_WIDTH-1:0]         rd0_addr,
    output logic [PTR_WIDTH-1:0]          rd0_tag,
    output logic                          rd1_en,
    output logic [ADDR_WIDTH-1:0]         rd1_addr,
    output logic [PTR_WIDTH-1:0]          rd1_tag,
    output logic [PTR_WIDTH-1:0]          prio_ptr
);

    // Unpacked view of the flat request-address bus.
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Per-cycle read capacity: free ports, forced to zero by flush or reset.
    logic [1:0] capacity;

    // Capacity is the count of free ports unless the pipeline is flushing.
    always_comb begin
        capacity = 2'(!port_busy[0]) + 2'(!port_busy[1]);
        if (flush || rst) begin
            capacity = 2'd0;
        end
    end

    // First and second valid requesters in search order from prio_ptr.
    logic                 g0_found;
    logic                 g1_found;
    logic [PTR_WIDTH-1:0] g0;
    logic [PTR_WIDTH-1:0] g1;

    // Scan requesters prio_ptr, prio_ptr+1, ... wrapping modulo NUM_REQ.
    always_comb begin
        logic [PTR_WIDTH-1:0] idx;
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned; otherwise synthesis would infer a latch.
        g0_found = 1'b0;
        g1_found = 1'b0;
        g0       = '0;
        g1       = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Power-of-two NUM_REQ makes the natural overflow the wrap.
            idx = prio_ptr + PTR_WIDTH'(k);
            if (req_valid[idx]) begin
                if (!g0_found) begin
                    g0       = idx;
                    g0_found = 1'b1;
                end else if (!g1_found) begin
                    g1       = idx;
                    g1_found = 1'b1;
                end
            end
        end
    end

    // Grants limited by capacity, and their routing onto physical ports.
    logic                 grant0;
    logic                 grant1;
    logic                 p0_grant;
    logic                 p1_grant;
    logic [PTR_WIDTH-1:0] p0_idx;
    logic [PTR_WIDTH-1:0] p1_idx;

    // Issue grants and steer them: with one free port g0 takes whichever
    // port is free; with two, g0 takes port 0 and g1 takes port 1.
    always_comb begin
        grant0    = g0_found && (capacity != 2'd0);
        grant1    = g1_found && (capacity == 2'd2);
        p0_grant  = 1'b0;
        p1_grant  = 1'b0;
        p0_idx    = g0;
        p1_idx    = g1;
        req_ready = '0;
        if (grant0) begin
            req_ready[g0] = 1'b1;
        end
        if (grant1) begin
            req_ready[g1] = 1'b1;
        end
        if (capacity == 2'd2) begin
            p0_grant = grant0;
            p1_grant = grant1;
        end else if (capacity == 2'd1) begin
            if (port_busy[0]) begin
                p1_grant = grant0;
                p1_idx   = g0;
            end else begin
                p0_grant = grant0;
            end
        end
    end

    // Register port outputs; addr/tag update only when the port is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd0_en   <= 1'b0;
            rd0_addr <= '0;
            rd0_tag  <= '0;
            rd1_en   <= 1'b0;
            rd1_addr <= '0;
            rd1_tag  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values and the order of statements does not matter.
            rd0_en <= p0_grant;
            rd1_en <= p1_grant;
            if (p0_grant) begin
                rd0_addr <= addr_arr[p0_idx];
                rd0_tag  <= p0_idx;
            end
            if (p1_grant) begin
                rd1_addr <= addr_arr[p1_idx];
                rd1_tag  <= p1_idx;
            end
        end
    end

    // Advance the priority pointer past the last requester granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_ptr <= '0;
        end else if (flush) begin
            prio_ptr <= '0;
        end else if (grant1) begin
            prio_ptr <= g1 + PTR_WIDTH'(1);
        end else if (grant0) begin
            prio_ptr <= g0 + PTR_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_vrf_read_port_arbiter.sv
// Self-checking bench for vrf_read_port_arbiter: directed scenarios followed
// by randomized traffic checked against a list-based reference model.
module tb_vrf_read_port_arbiter;

    localparam int N  = 8;
    localparam int PW = 3;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [1:0]      port_busy;
    logic            flush;
    logic            rd0_en, rd1_en;
    logic [AW-1:0]   rd0_addr, rd1_addr;
    logic [PW-1:0]   rd0_tag, rd1_tag;
    logic [PW-1:0]   prio_ptr;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int           m_ptr;
    int           m_ptr_next;
    logic [N-1:0] exp_ready;
    logic         exp_en0, exp_en1;
    int           exp_tag0, exp_tag1;
    int           exp_addr0, exp_addr1;
    logic [N-1:0] obs_ready;

    vrf_read_port_arbiter #(.NUM_REQ(N), .PTR_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .port_busy(port_busy), .flush(flush),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_tag(rd0_tag),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_tag(rd1_tag),
        .prio_ptr(prio_ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int addr_of(input int i);
        return int'(req_addr[i*AW +: AW]);
    endfunction

    // Build the ordered list of winners from the rules, then route them.
    task automatic model_eval();
        int cap;
        int wins[$];
        cap = flush ? 0 : ((port_busy[0] ? 0 : 1) + (port_busy[1] ? 0 : 1));
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i] && wins.size() < cap) wins.push_back(i);
        end
        exp_ready = '0;
        foreach (wins[j]) exp_ready[wins[j]] = 1'b1;
        exp_en0 = 1'b0;
        exp_en1 = 1'b0;
        if (wins.size() == 2) begin
            exp_en0 = 1'b1; exp_tag0 = wins[0];
            exp_en1 = 1'b1; exp_tag1 = wins[1];
        end else if (wins.size() == 1) begin
            if (cap == 1 && port_busy[0]) begin
                exp_en1 = 1'b1; exp_tag1 = wins[0];
            end else begin
                exp_en0 = 1'b1; exp_tag0 = wins[0];
            end
        end
        if (exp_en0) exp_addr0 = addr_of(exp_tag0);
        if (exp_en1) exp_addr1 = addr_of(exp_tag1);
        if (flush) m_ptr_next = 0;
        else if (wins.size() > 0) m_ptr_next = (wins[wins.size()-1] + 1) % N;
        else m_ptr_next = m_ptr;
    endtask

    // One clock cycle: drive, check combinational grant, check registered result.
    task automatic step(input logic [N-1:0] v, input logic [1:0] b, input logic f);
        req_valid = v;
        port_busy = b;
        flush     = f;
        #1;
        model_eval();
        obs_ready = req_ready;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("prio_ptr", 32'(prio_ptr), 32'(m_ptr));
        @(posedge clk);
        #1;
        m_ptr = m_ptr_next;
        check("rd0_en", 32'(rd0_en), 32'(exp_en0));
        check("rd1_en", 32'(rd1_en), 32'(exp_en1));
        if (exp_en0) begin
            check("rd0_addr", 32'(rd0_addr), 32'(exp_addr0));
            check("rd0_tag", 32'(rd0_tag), 32'(exp_tag0));
        end
        if (exp_en1) begin
            check("rd1_addr", 32'(rd1_addr), 32'(exp_addr1));
            check("rd1_tag", 32'(rd1_tag), 32'(exp_tag1));
        end
    endtask

    initial begin
        logic [N-1:0] pending;
        logic [N-1:0] v;
        logic [1:0]   b;
        logic         f;

        // Reset; req_ready must stay low while rst is high even with requests.
        rst       = 1'b1;
        req_valid = '1;
        port_busy = 2'b00;
        flush     = 1'b0;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(i + 10);
        #2;
        check("ready_in_reset", 32'(req_ready), 32'h0);
        check("rd0_en_reset", 32'(rd0_en), 32'h0);
        check("rd1_en_reset", 32'(rd1_en), 32'h0);
        check("rd0_addr_reset", 32'(rd0_addr), 32'h0);
        check("ptr_reset", 32'(prio_ptr), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_ptr = 0;

        // Idle for five cycles.
        for (int c = 0; c < 5; c++) step('0, 2'b00, 1'b0);
        check("idle_ptr", 32'(prio_ptr), 32'h0);

        // Round-robin rotation with all requesters valid.
        step('1, 2'b00, 1'b0);
        check("rr0_ready", 32'(obs_ready), 32'h03);
        check("rr0_rd0_addr", 32'(rd0_addr), 32'd10);
        check("rr0_rd0_tag", 32'(rd0_tag), 32'd0);
        check("rr0_rd1_addr", 32'(rd1_addr), 32'd11);
        check("rr0_rd1_tag", 32'(rd1_tag), 32'd1);
        check("rr0_ptr", 32'(prio_ptr), 32'd2);
        step('1, 2'b00, 1'b0);
        check("rr1_ready", 32'(obs_ready), 32'h0C);
        step('1, 2'b00, 1'b0);
        check("rr2_ready", 32'(obs_ready), 32'h30);
        step('1, 2'b00, 1'b0);
        check("rr3_ready", 32'(obs_ready), 32'hC0);
        check("rr3_ptr_wrap", 32'(prio_ptr), 32'd0);

        // Single requester with two free ports lands on port 0 only; ptr -> 6.
        step(8'h20, 2'b00, 1'b0);
        check("single_rd1_en", 32'(rd1_en), 32'h0);
        check("single_ptr", 32'(prio_ptr), 32'd6);

        // Wrapping search from ptr=6 over requesters 6 and 0.
        step(8'h41, 2'b00, 1'b0);
        check("wrap_ready", 32'(obs_ready), 32'h41);
        check("wrap_rd0_tag", 32'(rd0_tag), 32'd6);
        check("wrap_rd1_tag", 32'(rd1_tag), 32'd0);
        check("wrap_ptr", 32'(prio_ptr), 32'd1);

        // Move ptr to 5, then flush with everyone requesting.
        step(8'h10, 2'b00, 1'b0);
        check("pre_flush_ptr", 32'(prio_ptr), 32'd5);
        step('1, 2'b00, 1'b1);
        check("flush_ready", 32'(obs_ready), 32'h0);
        check("flush_rd0_en", 32'(rd0_en), 32'h0);
        check("flush_rd1_en", 32'(rd1_en), 32'h0);
        check("flush_ptr", 32'(prio_ptr), 32'd0);

        // Port 0 busy: the single grant goes to port 1.
        step(8'h18, 2'b01, 1'b0);
        check("busy_ready", 32'(obs_ready), 32'h08);
        check("busy_rd0_en", 32'(rd0_en), 32'h0);
        check("busy_rd1_en", 32'(rd1_en), 32'h1);
        check("busy_rd1_tag", 32'(rd1_tag), 32'd3);
        check("busy_ptr", 32'(prio_ptr), 32'd4);
        step(8'h18, 2'b11, 1'b0);
        check("both_busy_ready", 32'(obs_ready), 32'h0);
        check("both_busy_ptr", 32'(prio_ptr), 32'd4);

        // Two requesters reading the same register are both granted.
        req_addr[1*AW +: AW] = AW'(7);
        req_addr[2*AW +: AW] = AW'(7);
        step(8'h06, 2'b00, 1'b0);
        check("same_reg_ready", 32'(obs_ready), 32'h06);
        check("same_reg_rd0_addr", 32'(rd0_addr), 32'd7);
        check("same_reg_rd1_addr", 32'(rd1_addr), 32'd7);

        // Randomized traffic: requests hold valid and address until granted.
        pending = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 2) == 0) begin
                    pending[i] = 1'b1;
                    req_addr[i*AW +: AW] = AW'($urandom_range(0, 31));
                end
            end
            b = 2'($urandom_range(0, 3));
            f = ($urandom_range(0, 19) == 0);
            v = pending;
            step(v, b, f);
            pending = pending & ~exp_ready;
        end

        // Asynchronous reset between edges while port 0 is active.
        req_addr[0 +: AW] = AW'(21);
        step(8'h01, 2'b00, 1'b0);
        check("pre_rst_rd0_en", 32'(rd0_en), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rd0_en", 32'(rd0_en), 32'h0);
        check("async_rd0_addr", 32'(rd0_addr), 32'h0);
        check("async_rd0_tag", 32'(rd0_tag), 32'h0);
        check("async_ptr", 32'(prio_ptr), 32'h0);
        check("async_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        check("rst_held_rd0_en", 32'(rd0_en), 32'h0);
        rst   = 1'b0;
        m_ptr = 0;
        step(8'h81, 2'b00, 1'b0);
        check("post_rst_ptr", 32'(prio_ptr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vrf_read_port_arbiter.md
Name: vrf_read_port_arbiter

Overview:
- Shares the two vector-register-file read ports between NUM_REQ requesters, such as functional-unit operand collectors.
- Each cycle it grants up to two valid requesters in round-robin order, starting from a rotating priority pointer.
- Winners are routed to the free read ports, and the port address/tag outputs are registered.
- It sits between the operand-collector request buses and the VRF read-address inputs.

Parameters:
NUM_REQ, 8, number of requesters; must be a power of two and at least 2
PTR_WIDTH, 3, $clog2(NUM_REQ); width of the priority pointer and tags
ADDR_WIDTH, 5, width of a vector register index (32 registers)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester read request
req_addr  input  NUM_REQ*ADDR_WIDTH  register index; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_ready  output  NUM_REQ  combinational grant; a handshake occurs when valid&ready
port_busy  input  2  bit p=1: read port p is unavailable this cycle
flush  input  1  synchronous pipeline flush
rd0_en  output  1  port 0 read enable (registered)
rd0_addr  output  ADDR_WIDTH  port 0 register index
rd0_tag  output  PTR_WIDTH  requester index owning port 0
rd1_en  output  1  port 1 read enable (registered)
rd1_addr  output  ADDR_WIDTH  port 1 register index
rd1_tag  output  PTR_WIDTH  requester index owning port 1
prio_ptr  output  PTR_WIDTH  current highest-priority requester index

Behaviour:
- Reset (async, rst=1): prio_ptr=0; rd0_en=rd1_en=0; rd*_addr=0; rd*_tag=0. req_ready is 0 while rst=1.
- Capacity per cycle: C = number of zero bits in port_busy (0, 1 or 2). flush=1 forces C=0.
- Search order: requesters prio_ptr, prio_ptr+1, ..., wrapping mod NUM_REQ.
- First grant g0 = first valid requester in search order. Second grant g1 = next valid requester after g0 in search order, excluding g0.
- Grants are issued only up to C. req_ready is one-hot or two-hot over the granted requesters; it is never asserted for a requester with req_valid=0.
- Port routing:
  - C=2: g0 goes to port 0, g1 goes to port 1.
  - C=1: g0 goes to the single free port; no second grant.
  - C=0: no grants.
- Latency: a grant in cycle T drives rdP_en=1, rdP_addr=req_addr[g], rdP_tag=g at the register output in T+1.
- A port with no grant in T has rdP_en=0 in T+1. Its addr/tag hold their previous values and are don't-care when en=0.
- Pointer update at the end of T:
  - Two grants: prio_ptr <= (g1+1) mod NUM_REQ.
  - One grant: prio_ptr <= (g0+1) mod NUM_REQ.
  - No grant: unchanged.
  - Wrap: g=NUM_REQ-1 gives ptr=0.
- Fairness: any continuously valid requester is granted within ceil(NUM_REQ/2) cycles when C=2 every cycle, and within NUM_REQ cycles when C>=1 every cycle.
- Requesters hold req_valid and req_addr stable until granted. The arbiter does not latch requests.
- flush=1 in cycle T: req_ready=0 in T; rd0_en=rd1_en=0 in T+1; prio_ptr <= 0.
- Single valid requester with C=2: granted on port 0 only; rd1_en=0.
- rst asserted mid-operation: all outputs return to reset values immediately; any grant in flight is discarded.
- Two requesters targeting the same register: both are granted independently; no merging.

Test Plan:
- Reset then all-idle: rst pulse, req_valid=0 for 5 cycles -> rd0_en=rd1_en=0, prio_ptr=0, req_ready=0.
- Round-robin rotation, all 8 valid, port_busy=00, addrs i+10:
  - cycle 0: ready=0x03; next cycle rd0=(addr 10, tag 0), rd1=(addr 11, tag 1), ptr=2.
  - cycle 1: ready=0x0C.
  - cycles 0-3 grant pairs {0,1},{2,3},{4,5},{6,7}; ptr wraps to 0 after cycle 3.
- Wrap search: ptr=6, req_valid=0x41 (reqs 0 and 6) -> g0=6 on port 0, g1=0 on port 1, ptr becomes 1.
- Port busy: port_busy=01, req_valid=0x18 (reqs 3 and 4), ptr=0 -> ready=0x08; next cycle rd1_en=1, rd1_tag=3, rd0_en=0; ptr=4.
  - port_busy=11 -> ready=0, ptr unchanged.
- Flush: valid=0xFF, ptr=5, flush=1 -> ready=0; next cycle rd0_en=rd1_en=0, ptr=0.
- Async reset mid-stream: assert rst between clock edges while rd0_en=1 -> rd0_en drops to 0 before the next edge; ptr=0.
